// File: rtl/lms_w_update_gen.sv
// lms_w_update_gen: LMS/NLMS coefficient updater with leakage and saturation.
// Owns the coefficient RAM; reads the reference buffer through a 1-cycle port.
module lms_w_update_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int W_WIDTH    = 32,
    parameter int TAPS       = 512,
    parameter int AW         = 9,
    parameter int MU_SHIFT   = 15,
    parameter int LEAK_SHIFT = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         clear,
    input  logic                         mode,
    input  logic                         leak_en,
    input  logic [5:0]                   norm_shift,
    input  logic signed [DATA_WIDTH-1:0] err_data,
    output logic [AW-1:0]                u_rd_addr,
    input  logic signed [DATA_WIDTH-1:0] u_rd_data,
    input  logic [AW-1:0]                coef_rd_addr,
    output logic [W_WIDTH-1:0]           coef_rd_data,
    output logic                         busy,
    output logic                         done,
    output logic [AW:0]                  sat_cnt
);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_UPD   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_CLR   = 3'd4;

    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = ((PW > W_WIDTH) ? PW : W_WIDTH) + 2;

    localparam logic [AW-1:0] LAST  = AW'(TAPS - 1);
    localparam logic [6:0]    MU_SH = 7'(MU_SHIFT);

    localparam logic signed [SW-1:0] WMAX =
        (SW'(1) <<< (W_WIDTH - 1)) - SW'(1);
    localparam logic signed [SW-1:0] WMIN = -WMAX - SW'(1);

    logic [2:0]    state;
    logic [AW-1:0] clr_addr;

    logic signed [DATA_WIDTH-1:0] e_q;
    logic                         mode_q;
    logic                         leak_q;
    logic [5:0]                   ns_q;

    logic          v1, v2, v3, v4;
    logic [AW-1:0] a1, a2, a3, a4;

    logic signed [W_WIDTH-1:0] w_q, w2, w3, wb_d;
    logic signed [PW-1:0]      p2, p_sh;
    logic signed [SW-1:0]      d3;

    logic [6:0]           sh;
    logic signed [SW-1:0] w_ext, w_lk, s_sum, s_sat;
    logic                 clip;

    logic clr_we, upd_we;

    logic [W_WIDTH-1:0] ram [0:TAPS-1];

    assign sh = MU_SH + (mode_q ? {1'b0, ns_q} : 7'd0);
    assign p_sh = p2 >>> sh;

    assign clr_we = busy && (state == S_INIT || state == S_CLR);
    assign upd_we = v4 && !clear;

    // Leak, accumulate and clip the tap in the third pipeline stage.
    always_comb begin
        w_ext = SW'(w3);
        w_lk  = w_ext - (w_ext >>> LEAK_SHIFT);
        s_sum = (leak_q ? w_lk : w_ext) + d3;
        s_sat = s_sum;
        clip  = 1'b0;
        if (s_sum > WMAX) begin
            s_sat = WMAX;
            clip  = 1'b1;
        end else if (s_sum < WMIN) begin
            s_sat = WMIN;
            clip  = 1'b1;
        end
    end

    // Coefficient RAM: one write port, update read and FIR read (read-first).
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clr_we) begin
                ram[clr_addr] <= '0;
            end else if (upd_we) begin
                ram[a4] <= wb_d;
            end
        end
        w_q          <= ram[u_rd_addr];
        coef_rd_data <= ram[coef_rd_addr];
    end

    // Datapath registers; qualified by the valid chain, so no reset needed.
    always_ff @(posedge clk) begin
        a1   <= u_rd_addr;
        a2   <= a1;
        a3   <= a2;
        a4   <= a3;
        p2   <= PW'(u_rd_data) * PW'(e_q);
        w2   <= w_q;
        d3   <= SW'(p_sh);
        w3   <= w2;
        wb_d <= s_sat[W_WIDTH-1:0];
    end

    // Control FSM, valid chain, saturation counter and done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_INIT;
            busy      <= 1'b0;
            done      <= 1'b0;
            u_rd_addr <= '0;
            sat_cnt   <= '0;
            clr_addr  <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            v4        <= 1'b0;
            e_q       <= '0;
            mode_q    <= 1'b0;
            leak_q    <= 1'b0;
            ns_q      <= '0;
        end else begin
            done <= 1'b0;
            v1   <= (state == S_UPD) && !clear;
            v2   <= v1 && !clear;
            v3   <= v2 && !clear;
            v4   <= v3 && !clear;
            if (v3 && !clear && clip && sat_cnt != '1) begin
                sat_cnt <= sat_cnt + 1'b1;
            end
            unique case (state)
                S_INIT, S_CLR: begin
                    if (clear || !busy) begin
                        busy     <= 1'b1;
                        clr_addr <= '0;
                    end else if (clr_addr == LAST) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (clear) begin
                        state    <= S_CLR;
                        busy     <= 1'b1;
                        clr_addr <= '0;
                    end else if (start) begin
                        state     <= S_UPD;
                        busy      <= 1'b1;
                        u_rd_addr <= '0;
                        e_q       <= err_data;
                        mode_q    <= mode;
                        leak_q    <= leak_en;
                        ns_q      <= norm_shift;
                        sat_cnt   <= '0;
                    end
                end
                S_UPD: begin
                    if (clear) begin
                        state    <= S_CLR;
                        clr_addr <= '0;
                    end else if (u_rd_addr == LAST) begin
                        state <= S_DRAIN;
                    end else begin
                        u_rd_addr <= u_rd_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (clear) begin
                        state    <= S_CLR;
                        clr_addr <= '0;
                    end else if (!(v1 || v2 || v3 || v4)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_INIT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lms_w_update_gen.sv
// tb_lms_w_update_gen: directed vectors with a done-driven scoreboard.
// Small build: TAPS=8, W_WIDTH=20, LEAK_SHIFT=4.
module tb_lms_w_update_gen;

    localparam int DW   = 16;
    localparam int WW   = 20;
    localparam int TAPS = 8;
    localparam int AW   = 3;
    localparam int WSAT = 524287;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 clear;
    logic                 mode;
    logic                 leak_en;
    logic [5:0]           norm_shift;
    logic signed [DW-1:0] err_data;
    logic [AW-1:0]        u_rd_addr;
    logic signed [DW-1:0] u_rd_data;
    logic [AW-1:0]        coef_rd_addr;
    logic [WW-1:0]        coef_rd_data;
    logic                 busy;
    logic                 done;
    logic [AW:0]          sat_cnt;

    typedef struct {
        int t_ref;
        int lat;
        int bsy;
        int w;
        int sat;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   cyc    = 0;
    int   n_push = 0;
    int   n_chk  = 0;
    bit   ended  = 1'b0;

    logic signed [DW-1:0] u_mem [TAPS];

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) u_rd_data <= u_mem[u_rd_addr];

    lms_w_update_gen #(
        .DATA_WIDTH(DW),
        .W_WIDTH(WW),
        .TAPS(TAPS),
        .AW(AW),
        .MU_SHIFT(15),
        .LEAK_SHIFT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .clear(clear),
        .mode(mode),
        .leak_en(leak_en),
        .norm_shift(norm_shift),
        .err_data(err_data),
        .u_rd_addr(u_rd_addr),
        .u_rd_data(u_rd_data),
        .coef_rd_addr(coef_rd_addr),
        .coef_rd_data(coef_rd_data),
        .busy(busy),
        .done(done),
        .sat_cnt(sat_cnt)
    );

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic summary();
        ended = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    endtask

    task automatic push(int lat, int bsy, int w, int sat);
        exp_t e;
        e.t_ref = cyc + 1;
        e.lat   = lat;
        e.bsy   = bsy;
        e.w     = w;
        e.sat   = sat;
        q.push_back(e);
        n_push++;
    endtask

    task automatic wait_chk();
        int t;
        t = 0;
        while (n_chk != n_push && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (n_chk != n_push) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: checked %0d, want %0d", n_chk, n_push);
            summary();
            $finish;
        end
    endtask

    task automatic set_u(logic signed [DW-1:0] u);
        for (int k = 0; k < TAPS; k++) u_mem[k] = u;
    endtask

    task automatic upd(logic signed [DW-1:0] e, logic signed [DW-1:0] u,
                       logic m, logic l, logic [5:0] ns, int w, int sat);
        set_u(u);
        @(negedge clk);
        err_data   = e;
        mode       = m;
        leak_en    = l;
        norm_shift = ns;
        start      = 1'b1;
        push(13, 13, w, sat);
        @(negedge clk);
        start      = 1'b0;
        err_data   = 16'sh1234;
        mode       = ~m;
        leak_en    = ~l;
        norm_shift = 6'd40;
        wait_chk();
    endtask

    task automatic clr(int sat);
        @(negedge clk);
        clear = 1'b1;
        push(8, 8, 0, sat);
        @(negedge clk);
        clear = 1'b0;
        wait_chk();
    endtask

    // Monitor: every done pops one expectation and reads all taps back.
    initial begin : mon
        int   bcnt;
        exp_t e;
        bcnt = 0;
        coef_rd_addr = '0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) bcnt++;
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: at cycle %0d, want none", cyc);
                end else begin
                    e = q.pop_front();
                    chk("latency", cyc - e.t_ref, e.lat);
                    chk("busy_cycles", bcnt, e.bsy);
                    chk("sat_cnt", int'(sat_cnt), e.sat);
                    for (int k = 0; k < TAPS; k++) begin
                        coef_rd_addr = AW'(k);
                        @(negedge clk);
                        chk($sformatf("coef[%0d]", k),
                            int'($signed(coef_rd_data)), e.w);
                    end
                    n_chk++;
                end
                bcnt = 0;
            end
        end
    end

    // Watchdog: a stuck run still ends with a verdict.
    initial begin : wdog
        #300000;
        if (!ended) begin
            n_vec++;
            n_err++;
            $display("FAIL watchdog: cycle %0d, want finish", cyc);
            summary();
            $finish;
        end
    end

    initial begin : stim
        int w;
        rst_n      = 1'b0;
        start      = 1'b0;
        clear      = 1'b0;
        mode       = 1'b0;
        leak_en    = 1'b0;
        norm_shift = '0;
        err_data   = '0;
        set_u(16'sh0000);
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_sat", int'(sat_cnt), 0);
        chk("rst_addr", int'(u_rd_addr), 0);

        push(8, 8, 0, 0);
        rst_n = 1'b1;
        wait_chk();

        upd(16'sh4000, 16'sh4000, 1'b0, 1'b0, 6'd0, 8192, 0);
        upd(16'sh4000, 16'sh4000, 1'b0, 1'b0, 6'd0, 16384, 0);
        clr(0);

        upd(16'sh8000, 16'sh7fff, 1'b1, 1'b0, 6'd0, -32767, 0);
        upd(16'sh4000, 16'sh4000, 1'b1, 1'b0, 6'd3, -31743, 0);
        clr(0);

        upd(16'sh4000, 16'sh4000, 1'b0, 1'b0, 6'd0, 8192, 0);
        upd(16'sh0000, 16'sh4000, 1'b0, 1'b1, 6'd0, 7680, 0);
        upd(16'sh0000, 16'sh4000, 1'b0, 1'b1, 6'd0, 7200, 0);

        set_u(16'sh4000);
        @(negedge clk);
        err_data = 16'sh4000;
        mode     = 1'b0;
        leak_en  = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        push(8, 11, 0, 0);
        @(negedge clk);
        clear = 1'b0;
        wait_chk();
        repeat (20) @(negedge clk);

        @(negedge clk);
        err_data = 16'sh4000;
        start    = 1'b1;
        clear    = 1'b1;
        push(8, 8, 0, 0);
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        wait_chk();
        repeat (20) @(negedge clk);

        for (int n = 1; n <= 64; n++) begin
            w = n * 8192;
            if (w > WSAT) begin
                upd(16'sh4000, 16'sh4000, 1'b0, 1'b0, 6'd0, WSAT, 8);
            end else begin
                upd(16'sh4000, 16'sh4000, 1'b0, 1'b0, 6'd0, w, 0);
            end
        end

        repeat (10) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        summary();
        $finish;
    end

endmodule
